// File: rtl/divn_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
package divn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int unsigned DIV_MIN = 2;

  function automatic logic is_legal_div(input int unsigned div);
    return div >= DIV_MIN;
  endfunction

endpackage

// File: rtl/divn_rt_core.sv
// Divide-by-N core with a runtime divisor; the negedge stage stretches the
// high phase by half an sclk cycle so odd divisors still give 50% duty.
module divn_rt_core #(
  parameter int WIDTH = 4
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_div_cur,
  input  logic             i_commit,
  output logic             o_wrap_last,
  output logic             o_clk
);

  logic [WIDTH-1:0] r_cnt_p;
  logic             r_clk_p;
  logic             r_clk_n;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_clk_nxt;

  assign w_half      = i_div_cur >> 1;
  assign o_wrap_last = (r_cnt_p == (i_div_cur - WIDTH'(1)));

  // clk_p always reflects the count it is registered with; a commit restarts
  // the period at count 0, which is high for every legal divisor.
  always_comb begin
    w_cnt_nxt = (i_commit || o_wrap_last) ? '0 : r_cnt_p + WIDTH'(1);
    w_clk_nxt = i_commit | (w_cnt_nxt < w_half);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_p <= '0;
      r_clk_p <= 1'b1;
    end else begin
      r_cnt_p <= w_cnt_nxt;
      r_clk_p <= w_clk_nxt;
    end
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) r_clk_n <= 1'b1;
    else        r_clk_n <= r_clk_p;
  end

  assign o_clk = i_div_cur[0] ? (r_clk_p | r_clk_n) : r_clk_p;

endmodule

// File: rtl/divn_ratio_ctrl.sv
// Divide-ratio controller: accepts a divisor over a req/ack handshake and
// commits it only on the last cycle of an output period.
module divn_ratio_ctrl
  import divn_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int N_DEFAULT = 5
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_ack,
  output logic             o_err,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_div,
  output logic             o_clk
);

  state_t           r_state;
  logic [WIDTH-1:0] r_div_cur;
  logic [WIDTH-1:0] r_div_nxt;
  logic             r_err;
  logic             r_ack;
  logic             r_busy;
  logic             w_wrap_last;
  logic             w_commit;

  assign w_commit = (r_state == PEND) && w_wrap_last;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_div_cur <= WIDTH'(N_DEFAULT);
      r_div_nxt <= WIDTH'(N_DEFAULT);
      r_err     <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_busy <= 1'b1;
            if (is_legal_div(32'(i_div))) begin
              r_div_nxt <= i_div;
              r_state   <= PEND;
            end else begin
              r_err   <= 1'b1;
              r_ack   <= 1'b1;
              r_state <= ACK;
            end
          end
        end
        // Commit lands on the period boundary even if i_req was dropped early.
        PEND: begin
          if (w_commit) begin
            r_div_cur <= r_div_nxt;
            r_err     <= 1'b0;
            r_ack     <= 1'b1;
            r_state   <= ACK;
          end
        end
        ACK: begin
          if (!i_req) begin
            r_err   <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  divn_rt_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .i_div_cur  (r_div_cur),
    .i_commit   (w_commit),
    .o_wrap_last(w_wrap_last),
    .o_clk      (o_clk)
  );

  assign o_ack  = r_ack;
  assign o_err  = r_err;
  assign o_busy = r_busy;
  assign o_div  = r_div_cur;

endmodule

// File: tb/tb_divn_ratio_ctrl.sv
// Scoreboard bench for divn_ratio_ctrl: half-cycle waveform model plus a
// queue of expected handshake responses popped on each o_ack rise.
module tb_divn_ratio_ctrl;

  localparam int W     = 4;
  localparam int N_DEF = 5;

  logic         sclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_req = 1'b0;
  logic [W-1:0] i_div = '0;
  logic         o_ack, o_err, o_busy, o_clk;
  logic [W-1:0] o_div;

  divn_ratio_ctrl #(.WIDTH(W), .N_DEFAULT(N_DEF)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .i_req (i_req),
    .i_div (i_div),
    .o_ack (o_ack),
    .o_err (o_err),
    .o_busy(o_busy),
    .o_div (o_div),
    .o_clk (o_clk)
  );

  always #5 sclk = ~sclk;

  typedef struct {int err; int div;} exp_t;
  exp_t sb_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: active divisor, position in the period, handshake phase
  // (0 idle, 1 waiting for period boundary, 2 acknowledged).
  int m_n   = N_DEF;
  int m_pos = 0;
  int m_st  = 0;
  int m_nxt = N_DEF;
  int m_err = 0;
  int m_old;
  bit m_bnd;
  bit prev_ack = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(posedge sclk) begin
    if (!rst_n) begin
      m_n = N_DEF; m_pos = 0; m_st = 0; m_nxt = N_DEF; m_err = 0;
    end else begin
      m_old = m_st;
      m_bnd = (m_pos == m_n - 1);
      if (m_old == 1 && m_bnd) begin
        m_n = m_nxt; m_pos = 0; m_st = 2; m_err = 0;
      end else begin
        m_pos = m_bnd ? 0 : m_pos + 1;
      end
      if (m_old == 0 && i_req) begin
        if (int'(i_div) >= 2) begin m_nxt = int'(i_div); m_st = 1; end
        else begin m_st = 2; m_err = 1; end
      end else if (m_old == 2 && !i_req) begin
        m_st = 0;
      end
    end
    #1;
    if (!rst_n) begin
      chk("rst_clk", o_clk, 1);
      chk("rst_div", o_div, N_DEF);
      chk("rst_ack", o_ack, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_err", o_err, 0);
    end else begin
      chk("clk_hi_half", o_clk, (2 * m_pos < m_n) ? 1 : 0);
      chk("div", o_div, m_n);
      chk("ack", o_ack, (m_st == 2) ? 1 : 0);
      chk("busy", o_busy, (m_st != 0) ? 1 : 0);
      if (m_st == 2) chk("err_level", o_err, m_err);
    end
    if (o_ack && !prev_ack) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_err", o_err, e.err);
        chk("sb_div", o_div, e.div);
      end
    end
    prev_ack = o_ack;
  end

  always @(negedge sclk) begin
    #1;
    if (!rst_n) chk("rst_clk_lo_half", o_clk, 1);
    else        chk("clk_lo_half", o_clk, (2 * m_pos + 1 < m_n) ? 1 : 0);
  end

  task automatic wait_ack(input logic lvl, input int maxc);
    int c = 0;
    while (o_ack !== lvl && c < maxc) begin
      @(negedge sclk);
      c++;
    end
    chk("ack_wait", o_ack, lvl);
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (o_busy !== 1'b0 && c < maxc) begin
      @(negedge sclk);
      c++;
    end
    chk("idle_wait", o_busy, 0);
  endtask

  task automatic wait_pos(input int p);
    int c = 0;
    while (m_pos != p && c < 40) begin
      @(negedge sclk);
      c++;
    end
  endtask

  // Call on a negedge with the controller idle.
  task automatic do_req(input int div, input bit chg, input bit early);
    exp_t e;
    e.err = (div < 2) ? 1 : 0;
    e.div = (div < 2) ? m_n : div;
    sb_q.push_back(e);
    i_req = 1'b1;
    i_div = W'(div);
    @(negedge sclk);
    if (chg) i_div = W'($urandom_range(0, 15));
    if (early) begin
      i_req = 1'b0;
      wait_idle(40);
    end else begin
      wait_ack(1'b1, 40);
      @(negedge sclk);
      i_req = 1'b0;
      wait_ack(1'b0, 5);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sclk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge sclk);

    // Rejected divisors leave the clock alone.
    do_req(1, 1'b0, 1'b0);
    repeat (3) @(negedge sclk);
    do_req(0, 1'b0, 1'b0);
    repeat (4) @(negedge sclk);

    // Mid-period switch to 4.
    wait_pos(2);
    do_req(4, 1'b0, 1'b0);
    repeat (10) @(negedge sclk);

    // Extremes of the range.
    do_req(15, 1'b0, 1'b0);
    repeat (32) @(negedge sclk);
    do_req(2, 1'b0, 1'b0);
    repeat (6) @(negedge sclk);
    do_req(5, 1'b0, 1'b0);

    // Reset while a divisor of 7 is pending.
    wait_pos(0);
    i_req = 1'b1;
    i_div = W'(7);
    @(negedge sclk);
    chk("pend_busy", o_busy, 1);
    #2;
    rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    chk("async_rst_clk", o_clk, 1);
    chk("async_rst_div", o_div, N_DEF);
    chk("async_rst_busy", o_busy, 0);
    repeat (2) @(negedge sclk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge sclk);

    // Same-value request, then a request issued on the wrap cycle.
    do_req(5, 1'b0, 1'b0);
    repeat (2) @(negedge sclk);
    wait_pos(m_n - 1);
    do_req(3, 1'b0, 1'b0);
    repeat (8) @(negedge sclk);

    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 6)) @(negedge sclk);
      do_req(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
    end

    repeat (20) @(negedge sclk);
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/divn_ratio_ctrl.md
Name: divn_ratio_ctrl

Overview:
Runtime-programmable N-divider plus the controller that sequences divide-ratio changes glitch-free.
- Requester submits a new divisor over a four-phase req/ack handshake.
- Controller validates the divisor, holds it pending, and commits it only at an output-period boundary, so o_clk never produces a runt pulse.
- Sits between the system clock source and downstream logic that needs a reconfigurable slow clock with 50% duty for both odd and even N.

Parameters:
WIDTH, 4, width of divisor and period counter; legal divisors 2..2^WIDTH-1
N_DEFAULT, 5, divisor loaded at reset; must be in the legal range

Ports:
sclk  in  1  system clock; all state on posedge except the half-cycle stage
rst_n  in  1  asynchronous active-low reset
i_req  in  1  change request, level; held high until o_ack seen high
i_div  in  WIDTH  requested divisor; stable while i_req high
o_ack  out  1  acknowledge; high from commit (or reject) until i_req low
o_err  out  1  valid while o_ack high: 1 = request rejected (i_div < 2)
o_busy  out  1  high whenever FSM not IDLE
o_div  out  WIDTH  currently active divisor
o_clk  out  1  divided clock

Behaviour:
Reset values (async, rst_n low):
- state=IDLE; div_cur=N_DEFAULT; div_nxt=N_DEFAULT; cnt_p=0; clk_p=1; clk_n=1.
- o_clk=1, o_ack=0, o_err=0, o_busy=0, o_div=N_DEFAULT.
- Reset mid-operation discards any pending divisor.

Divider core (posedge sclk):
- cnt_p counts 0..div_cur-1, then wraps to 0.
- clk_p <= (cnt_p < div_cur>>1).

Half-cycle stage (negedge sclk):
- clk_n <= clk_p; reset to 1.
- No separate negedge counter.

Output mux:
- o_clk = div_cur[0] ? (clk_p | clk_n) : clk_p.
- Even N: high N/2 sclk cycles, low N/2.
- Odd N: high N/2 cycles exactly (half-cycle resolution).

FSM states: IDLE, PEND, ACK.
- IDLE, i_req=1, i_div>=2: div_nxt<=i_div, go PEND.
- IDLE, i_req=1, i_div<2: err<=1, go ACK. Divisor unchanged.
- PEND, on the posedge where cnt_p==div_cur-1 (last cycle of current period):
  - div_cur<=div_nxt, cnt_p<=0, err<=0, go ACK.
  - clk_p on that same edge uses the new divisor: (0 < div_nxt>>1) = 1.
- ACK: o_ack=1; stays until i_req=0, then IDLE. o_err holds err while in ACK.
- o_busy = (state!=IDLE).
- o_div = div_cur; updates on the commit edge.
- Commit latency: 1 to div_cur cycles after IDLE->PEND, depending on cnt_p phase. Worst case div_cur cycles.

Boundary conditions:
- i_req entering PEND on the exact wrap cycle: the commit waits for the next full period boundary.
- i_req dropped during PEND (protocol violation): the commit still happens; ACK exits on the next cycle.
- i_div == div_cur: full sequence runs, o_clk waveform unchanged.
- i_div changing while i_req high: only the value sampled on IDLE->PEND is used.
- Divisor 2^WIDTH-1: cnt_p reaches its max value with no overflow.

Decomposition:
Package divn_pkg:
- FSM state enum (IDLE/PEND/ACK, 2-bit).
- DIV_MIN = 2 constant.
- Function is_legal_div(div).

Sub-module divn_rt_core:
- Runtime-divisor core: cnt_p, clk_p, negedge clk_n, output mux.
- Inputs: div_cur, commit strobe.
- Output: wrap_last (cnt_p==div_cur-1).

FSM and handshake registers stay in divn_ratio_ctrl.

Test Plan:
1. Reset, no requests, N_DEFAULT=5 -> o_clk period 5 sclk, high 2.5/low 2.5; o_div=5; o_ack=o_busy=0.
2. Request i_div=4 mid-period -> o_clk completes the current 5-cycle period, first new period is high 2/low 2; o_div becomes 4 on the commit edge; o_ack rises the same edge and falls one cycle after i_req drops.
3. Request i_div=1, then i_div=0 -> each gives o_ack=1, o_err=1; o_div stays 5; o_clk undisturbed.
4. Request i_div=15, then 2 -> periods 15 (high 7.5) then 2 (high 1); no o_clk pulse shorter than 1 sclk cycle at either transition.
5. rst_n asserted while in PEND with i_div=7 -> o_clk=1 immediately, o_div=5, o_busy=0; after release the divider runs at 5 and no commit occurs.
6. i_div=3 requested on the wrap cycle (cnt_p=4) -> commit deferred to the end of the following 5-cycle period; i_div=5 (same value) -> ack returned, waveform identical.
